// File: rtl/alu_core.sv
// rtl/alu_core.sv - 8-bit multi-cycle ALU with sequential MUL/DIV engine
module alu_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [3:0]  op,
    input  logic        start,
    output logic [15:0] result,
    output logic [2:0]  flags,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_DIV = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  iter_cnt;

    // MUL: opa_q is the multiplicand, opb_q the multiplier shifted right each step.
    // DIV: opa_q holds the dividend and fills with quotient bits from the LSB,
    //      opb_q is the divisor, rem_q the running partial remainder.
    logic [7:0]  opa_q;
    logic [7:0]  opb_q;
    logic [15:0] prod_q;
    logic [7:0]  rem_q;

    logic        start_mul;
    logic        start_div;
    logic        last_iter;

    logic [7:0]  quick_low;
    logic        quick_carry;
    logic [8:0]  quick_sum;
    logic [15:0] quick_result;
    logic [2:0]  quick_flags;

    logic [15:0] mul_addend;
    logic [15:0] mul_next;
    logic [8:0]  div_trial;
    logic [8:0]  div_diff;
    logic        div_ge;
    logic [7:0]  div_rem_next;
    logic [7:0]  div_quo_next;

    assign start_mul = (op == OP_MUL);
    assign start_div = (op == OP_DIV) && (b != 8'h00);
    assign last_iter = (iter_cnt == 3'd7);
    assign busy      = (state != S_IDLE);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: multi-cycle ops leave IDLE, engines return after the 8th step
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && start_mul) begin
                    state_next = S_MUL;
                end else if (start && start_div) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle ops, including the divide-by-zero shortcut
    always_comb begin
        quick_low   = a;
        quick_carry = 1'b0;
        quick_sum   = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD: begin
                quick_low   = quick_sum[7:0];
                quick_carry = quick_sum[8];
            end
            OP_SUB: begin
                quick_low   = a - b;
                quick_carry = (a < b);
            end
            OP_AND: quick_low = a & b;
            OP_OR:  quick_low = a | b;
            OP_XOR: quick_low = a ^ b;
            OP_NOT: quick_low = ~a;
            OP_SHL: begin
                quick_low   = {a[6:0], 1'b0};
                quick_carry = a[7];
            end
            OP_SHR: begin
                quick_low   = {1'b0, a[7:1]};
                quick_carry = a[0];
            end
            OP_INC: begin
                quick_low   = a + 8'd1;
                quick_carry = (a == 8'hFF);
            end
            OP_DEC: begin
                quick_low   = a - 8'd1;
                quick_carry = (a == 8'h00);
            end
            default: quick_low = a;
        endcase

        if (op == OP_DIV) begin
            quick_result = 16'hFFFF;
            quick_flags  = 3'b110;
        end else begin
            quick_result = {8'h00, quick_low};
            quick_flags  = {quick_low[7], quick_carry, (quick_low == 8'h00)};
        end
    end

    // One shift-add step and one restoring-division step per cycle
    always_comb begin
        mul_addend   = opb_q[0] ? ({8'h00, opa_q} << iter_cnt) : 16'h0000;
        mul_next     = prod_q + mul_addend;
        div_trial    = {rem_q, opa_q[7]};
        div_diff     = div_trial - {1'b0, opb_q};
        div_ge       = (div_trial >= {1'b0, opb_q});
        div_rem_next = div_ge ? div_diff[7:0] : div_trial[7:0];
        div_quo_next = {opa_q[6:0], div_ge};
    end

    // Datapath: operand capture, iteration, and result/flag commit with done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iter_cnt <= 3'd0;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            prod_q   <= 16'h0000;
            rem_q    <= 8'h00;
            result   <= 16'h0000;
            flags    <= 3'b000;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa_q    <= a;
                        opb_q    <= b;
                        prod_q   <= 16'h0000;
                        rem_q    <= 8'h00;
                        iter_cnt <= 3'd0;
                        if (!(start_mul || start_div)) begin
                            result <= quick_result;
                            flags  <= quick_flags;
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod_q   <= mul_next;
                    opb_q    <= {1'b0, opb_q[7:1]};
                    iter_cnt <= iter_cnt + 3'd1;
                    if (last_iter) begin
                        result <= mul_next;
                        flags  <= {mul_next[15], (mul_next[15:8] != 8'h00), (mul_next == 16'h0000)};
                        done   <= 1'b1;
                    end
                end
                S_DIV: begin
                    rem_q    <= div_rem_next;
                    opa_q    <= div_quo_next;
                    iter_cnt <= iter_cnt + 3'd1;
                    if (last_iter) begin
                        result <= {div_rem_next, div_quo_next};
                        flags  <= {div_quo_next[7], 1'b0, (div_quo_next == 8'h00)};
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_core.md
# alu_core

Multi-cycle arithmetic/logic unit for the 8-bit datapath. Captures two 8-bit operands and an opcode on a start strobe and computes a 16-bit result plus three flags. Single-cycle ops finish in one cycle; MUL and DIV run an 8-iteration sequential engine. Sits directly upstream of the ALU result latch: `result` and `flags` feed the latch's result/flag inputs, and `done` is the strobe the control unit uses to assert the latch's grab.

## Interface
- No parameters; widths fixed (8-bit operands, 16-bit result).
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `a` input 8: operand A, sampled on accepted start.
- `b` input 8: operand B, sampled on accepted start.
- `op` input 4: opcode, sampled on accepted start.
- `start` input 1: request; accepted only in IDLE.
- `result` output 16: last completed result; held until next completion.
- `flags` output 3: [0]=zero, [1]=carry/borrow, [2]=negative; held with `result`.
- `busy` output 1: high while in MUL or DIV state.
- `done` output 1: one-cycle pulse when `result`/`flags` update.

## Operation
- Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SHR a (logical), 8 INC a, 9 DEC a, A MUL (unsigned), B DIV (unsigned a/b), C-F PASS a.
- 8-bit ops (0-9, C-F): result[15:8]=0, result[7:0]=op value; zero=(result[7:0]==0); negative=result[7].
- Carry: ADD carry-out; SUB borrow (a<b); SHL old a[7]; SHR old a[0]; INC set when a=FF; DEC set when a=00; logic/NOT/PASS 0.
- MUL: result=a*b (16-bit); zero=(result==0); negative=result[15]; carry=(result[15:8]!=0).
- DIV: result[7:0]=quotient, result[15:8]=remainder; zero=(quotient==0); negative=quotient[7]; carry=0.
- DIV by zero: no iteration; result=16'hFFFF, carry=1, zero=0, negative=1.
- States: IDLE, MUL, DIV. IDLE + start: op A → MUL; op B with b≠0 → DIV; all else complete immediately, stay IDLE.
- MUL: shift-add, one multiplier bit per cycle, LSB first, 8 iterations; then → IDLE with completion.
- DIV: restoring division, one quotient bit per cycle, MSB first, 8 iterations; then → IDLE with completion.
- Iteration counter 3-bit, counts 0..7; completion on the edge where counter=7.
- `start` while busy is ignored (not queued); operand/op changes while busy have no effect.
- Reset (any time, including mid-MUL/DIV): state=IDLE, counter=0, result=0, flags=0, busy=0, done=0; in-flight op discarded, no `done`.

## Timing
- Reset values: result=16'h0000, flags=3'b000, busy=0, done=0.
- Single-cycle ops and DIV-by-zero: start sampled at edge N; result/flags update at edge N; done high for cycle N→N+1. Latency 1.
- MUL/DIV: start at edge N enters state, busy=1 from N; iterations at edges N+1..N+8; result/flags update, busy falls, done pulses at edge N+8. Latency 9.
- A new start is accepted on the same edge that busy falls? No: busy falls at N+8 with state returning to IDLE; earliest new accept is edge N+9.
- Back-to-back single-cycle ops: start held high accepts one op per cycle, done high every cycle.
- done never asserts without a result/flags update; result/flags never change without done.

## Test plan
- Reset mid-MUL: start MUL a=0x0F b=0x0F, assert reset after 4 cycles → busy=0, done=0, result=0x0000, flags=0; no later done.
- ADD a=0xFF b=0x01 → after 1 cycle result=0x0000, flags=zero+carry (3'b011), done 1 cycle; SUB a=0x01 b=0x02 → result=0x00FF, flags=3'b110.
- MUL a=0xFF b=0xFF → busy 8 cycles, done at cycle 9, result=0xFE01, flags=3'b110; MUL a=0x00 b=0x37 → 0x0000, flags=3'b001.
- DIV a=0xC8 b=0x07 → 9 cycles, result=0x041C (q=0x1C, r=0x04), flags=3'b000; DIV a=0x05 b=0x00 → 1 cycle, result=0xFFFF, flags=3'b110.
- Start ADD while MUL busy → ignored; MUL result unchanged, single done pulse.
- SHL a=0x81 → result=0x0002, carry=1; SHR a=0x01 → result=0x0000, flags=3'b011; DEC a=0x00 → 0x00FF, flags=3'b110.
